// File: rtl/led_status_axil_rd_pkg.sv
// ============================================================================
// Module      : led_status_axil_rd_pkg
// Description : Shared constants for the LED/stop status AXI4-Lite read
//               responder: register offsets, response codes, FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_status_axil_rd_pkg;

  // Identification word returned at offset 0x00 ("LED0" in ASCII)
  localparam logic [31:0] ID_DEFAULT = 32'h4C45_4430;

  // Byte offsets of the mapped registers
  localparam logic [7:0] OFF_ID     = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_UPTIME = 8'h08;
  localparam logic [7:0] OFF_TOGGLE = 8'h0C;

  // Word selects derived from the offsets (address bits [3:2])
  localparam logic [1:0] SEL_ID     = OFF_ID[3:2];
  localparam logic [1:0] SEL_STATUS = OFF_STATUS[3:2];
  localparam logic [1:0] SEL_UPTIME = OFF_UPTIME[3:2];
  localparam logic [1:0] SEL_TOGGLE = OFF_TOGGLE[3:2];

  // AXI read response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Read FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/led_status_axil_rd_led_edge_cnt.sv
// ============================================================================
// Module      : led_edge_cnt
// Description : Rising-edge detector on led0 feeding a saturating 16-bit
//               counter with a clear input. A clear that coincides with an
//               edge leaves the counter at 1 so the edge is never lost.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_edge_cnt (
  input  logic        usr_clk,
  input  logic        usr_rst_n,
  input  logic        led,
  input  logic        clr,
  output logic [15:0] cnt
);

  logic led_d;
  logic rise;

  assign rise = led & ~led_d;

  // Delay led by one cycle for edge detection
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      led_d <= 1'b0;
    end else begin
      led_d <= led;
    end
  end

  // Saturating edge counter; clear wins over increment but keeps a same-cycle edge
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      cnt <= 16'h0000;
    end else if (clr) begin
      cnt <= rise ? 16'h0001 : 16'h0000;
    end else if (rise && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'h0001;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_status_axil_rd.sv
// ============================================================================
// Module      : led_status_axil_rd
// Description : AXI4-Lite read responder exposing ID, LED/stop status, a
//               free-running uptime counter and a clear-on-read LED toggle
//               count. One outstanding read, registered snapshot response,
//               SLVERR on unmapped offsets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_status_axil_rd
  import led_status_axil_rd_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic              usr_clk,
  input  logic              usr_rst_n,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  input  logic              led0,
  input  logic              stop
);

  logic [0:0]  state;
  logic        accept_en;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_code;
  logic [31:0] uptime;
  logic [15:0] toggle_cnt;

  logic        addr_mapped;
  logic [1:0]  word;
  logic        ar_hs;
  logic        toggle_clr;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        unused_addr_lsb;

  // Byte lanes within a word are don't-care for this register block
  assign unused_addr_lsb = ^s_axil_araddr[1:0];

  // Only offsets 0x00..0x0F can hit a register; anything above is unmapped
  assign addr_mapped = (s_axil_araddr[ADDR_W-1:4] == '0);
  assign word        = s_axil_araddr[3:2];
  assign ar_hs       = s_axil_arvalid && accept_en && (state == ST_IDLE);
  assign toggle_clr  = ar_hs && addr_mapped && (word == SEL_TOGGLE);

  // Read mux: value as seen in the handshake cycle
  always_comb begin
    rd_data = 32'h0000_0000;
    rd_resp = RESP_SLVERR;
    if (addr_mapped) begin
      rd_resp = RESP_OKAY;
      case (word)
        SEL_ID:     rd_data = ID_VALUE;
        SEL_STATUS: rd_data = {30'b0, stop, led0};
        SEL_UPTIME: rd_data = uptime;
        SEL_TOGGLE: rd_data = {16'b0, toggle_cnt};
        default:    rd_data = 32'h0000_0000;
      endcase
    end
  end

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      uptime <= 32'h0000_0000;
    end else begin
      uptime <= uptime + 32'h0000_0001;
    end
  end

  led_edge_cnt u_led_edge_cnt (
    .usr_clk   (usr_clk),
    .usr_rst_n (usr_rst_n),
    .led       (led0),
    .clr       (toggle_clr),
    .cnt       (toggle_cnt)
  );

  // Two-state read FSM with registered arready/rvalid and response snapshot
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      state      <= ST_IDLE;
      accept_en  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0000_0000;
      resp_code  <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            state      <= ST_RESP;
            accept_en  <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= rd_data;
            resp_code  <= rd_resp;
          end else begin
            accept_en  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (s_axil_rready) begin
            state      <= ST_IDLE;
            accept_en  <= 1'b1;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          accept_en  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s_axil_arready = accept_en;
  assign s_axil_rvalid  = resp_valid;
  assign s_axil_rdata   = resp_data;
  assign s_axil_rresp   = resp_code;

endmodule

`default_nettype wire

// File: tb/tb_led_status_axil_rd.sv
// ============================================================================
// Module      : tb_led_status_axil_rd
// Description : Self-checking bench for led_status_axil_rd. A register-level
//               model tracks uptime, toggle count and pending responses;
//               directed scenarios are followed by randomized reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_status_axil_rd;

  logic        usr_clk = 1'b0;
  logic        usr_rst_n = 1'b0;
  logic [15:0] s_axil_araddr = 16'h0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic        led0 = 1'b0;
  logic        stop = 1'b0;

  led_status_axil_rd #(
    .ADDR_W   (16),
    .ID_VALUE (32'h4C454430)
  ) dut (
    .usr_clk        (usr_clk),
    .usr_rst_n      (usr_rst_n),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .led0           (led0),
    .stop           (stop)
  );

  always #5 usr_clk = ~usr_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state: the register values as they stand right now
  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  logic [31:0] m_up = 32'h0;
  int          m_tog = 0;
  logic        m_led_prev = 1'b0;
  exp_t        exp_q[$];
  logic        hs_seen = 1'b0;
  logic [31:0] last_data = 32'h0;
  logic [1:0]  last_resp = 2'b00;

  function automatic exp_t ref_read(input logic [15:0] a);
    exp_t e;
    e.d = 32'h0;
    e.r = 2'b10;
    if ((a >> 4) == 16'h0) begin
      e.r = 2'b00;
      case (a[3:2])
        2'd0: e.d = 32'h4C454430;
        2'd1: e.d = {30'b0, stop, led0};
        2'd2: e.d = m_up;
        default: e.d = 32'(m_tog);
      endcase
    end
    return e;
  endfunction

  // Advance one clock: score the R channel, model the AR channel, step counters
  task automatic tick();
    logic rise;
    logic tog_rd;
    exp_t e;
    hs_seen = 1'b0;
    if (usr_rst_n) begin
      if (s_axil_rvalid && s_axil_rready) begin
        if (exp_q.size() == 0) begin
          check32("r_orphan", 32'(s_axil_rvalid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check32("rdata", s_axil_rdata, e.d);
          check32("rresp", 32'(s_axil_rresp), 32'(e.r));
          last_data = s_axil_rdata;
          last_resp = s_axil_rresp;
        end
      end
      rise   = led0 && !m_led_prev;
      tog_rd = 1'b0;
      if (s_axil_arvalid && s_axil_arready) begin
        e = ref_read(s_axil_araddr);
        exp_q.push_back(e);
        hs_seen = 1'b1;
        tog_rd  = ((s_axil_araddr >> 4) == 16'h0) && (s_axil_araddr[3:2] == 2'd3);
      end
      if (tog_rd) m_tog = rise ? 1 : 0;
      else if (rise && m_tog < 65535) m_tog++;
      m_up       = m_up + 32'd1;
      m_led_prev = led0;
    end else begin
      m_up       = 32'h0;
      m_tog      = 0;
      m_led_prev = 1'b0;
      exp_q.delete();
    end
    @(posedge usr_clk);
    #1;
  endtask

  // One full read: AR handshake, optional R stall, R handshake, idle gap
  task automatic rd(input logic [15:0] a, input int stall, input int gap);
    int n;
    s_axil_araddr  = a;
    s_axil_arvalid = 1'b1;
    s_axil_rready  = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!hs_seen && n < 20);
    check32("ar_accept", 32'(hs_seen), 32'd1);
    s_axil_arvalid = 1'b0;
    s_axil_araddr  = 16'($urandom);
    check32("rvalid_lat", 32'(s_axil_rvalid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      tick();
      check32("stall_rvalid", 32'(s_axil_rvalid), 32'd1);
      check32("stall_arready", 32'(s_axil_arready), 32'd0);
      if (exp_q.size() != 0) check32("stall_rdata", s_axil_rdata, exp_q[0].d);
    end
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;
    check32("post_rvalid", 32'(s_axil_rvalid), 32'd0);
    check32("post_arready", 32'(s_axil_arready), 32'd1);
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic pulse_led();
    led0 = 1'b0; tick(); tick();
    led0 = 1'b1; tick(); tick();
  endtask

  logic [31:0] u1;
  logic [15:0] addr_tbl [9];

  initial begin
    addr_tbl[0] = 16'h0000; addr_tbl[1] = 16'h0004; addr_tbl[2] = 16'h0008;
    addr_tbl[3] = 16'h000C; addr_tbl[4] = 16'h0010; addr_tbl[5] = 16'h0014;
    addr_tbl[6] = 16'h001C; addr_tbl[7] = 16'h1000; addr_tbl[8] = 16'h0007;

    // Reset state
    tick(); tick();
    check32("rst_arready", 32'(s_axil_arready), 32'd0);
    check32("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    check32("rst_rdata", s_axil_rdata, 32'h0);
    check32("rst_rresp", 32'(s_axil_rresp), 32'd0);
    usr_rst_n = 1'b1;
    check32("rel_arready", 32'(s_axil_arready), 32'd0);
    tick();
    check32("first_arready", 32'(s_axil_arready), 32'd1);

    // ID read
    rd(16'h0000, 0, 1);
    check32("id_value", last_data, 32'h4C454430);

    // STATUS with a 5-cycle R stall
    led0 = 1'b1; stop = 1'b1; tick(); tick();
    rd(16'h0004, 5, 1);
    check32("status_val", last_data, 32'h3);

    // TOGGLE: clear, three edges, clear-on-read, edge coincident with AR
    rd(16'h000C, 0, 0);
    pulse_led(); pulse_led(); pulse_led();
    rd(16'h000C, 0, 0);
    check32("tog_three", last_data, 32'h3);
    rd(16'h000C, 0, 0);
    check32("tog_cleared", last_data, 32'h0);
    pulse_led();
    led0 = 1'b0; tick(); tick();
    led0 = 1'b1;
    rd(16'h000C, 0, 0);
    check32("tog_coincide", last_data, 32'h1);
    rd(16'h000C, 0, 0);
    check32("tog_kept_edge", last_data, 32'h1);

    // Unmapped offsets then OKAY
    rd(16'h0014, 0, 0);
    check32("slverr_14", 32'(last_resp), 32'h2);
    rd(16'h1000, 1, 0);
    check32("slverr_1000", 32'(last_resp), 32'h2);
    check32("slverr_data", last_data, 32'h0);
    rd(16'h0000, 0, 0);
    check32("okay_after", 32'(last_resp), 32'h0);

    // UPTIME spacing of exactly 10 cycles
    rd(16'h0008, 0, 8);
    u1 = last_data;
    rd(16'h0008, 0, 0);
    check32("uptime_diff", last_data - u1, 32'd10);

    // UPTIME wrap at 2-cycle pitch
    force dut.uptime = 32'hFFFFFFFE;
    #1;
    release dut.uptime;
    m_up = 32'hFFFFFFFE;
    rd(16'h0008, 0, 0);
    check32("uptime_pre_wrap", last_data, 32'hFFFFFFFE);
    rd(16'h0008, 0, 0);
    check32("uptime_wrap", last_data, 32'h0);

    // Randomized reads with LED/stop activity
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) led0 = ~led0;
      if ($urandom_range(0, 3) == 0) stop = ~stop;
      rd(addr_tbl[$urandom_range(0, 8)], int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a response
    led0 = 1'b0;
    tick();
    s_axil_araddr  = 16'h0004;
    s_axil_arvalid = 1'b1;
    s_axil_rready  = 1'b0;
    tick();
    s_axil_arvalid = 1'b0;
    check32("mid_rvalid", 32'(s_axil_rvalid), 32'd1);
    #1;
    usr_rst_n = 1'b0;
    #1;
    check32("rst_drop_rvalid", 32'(s_axil_rvalid), 32'd0);
    check32("rst_drop_arready", 32'(s_axil_arready), 32'd0);
    tick(); tick();
    usr_rst_n = 1'b1;
    tick();
    check32("rerel_arready", 32'(s_axil_arready), 32'd1);
    check32("rerel_rvalid", 32'(s_axil_rvalid), 32'd0);
    rd(16'h000C, 0, 0);
    check32("tog_after_rst", last_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
